dcache_controller: RTL

// - Direct-mapped, write-back, write-allocate data cache between the 8-bit single-cycle CPU and data memory.
// - Presents the CPU's byte interface (READ/WRITE/ADDRESS/WRITEDATA/READDATA/BUSYWAIT) and services hits with no stall.
// - On a miss, stalls the CPU via BUSYWAIT and sequences block write-back and fetch on a 32-bit word memory port.
// - Owns the cache storage: 8 blocks x 4 bytes, plus tag, valid and dirty bits per block.

---
 rtl/dcache_controller.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped write-back write-allocate data cache, 8-bit CPU side, 32-bit memory side.
// Define DCACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT outputs.
module dcache_controller #(
    parameter int INDEX_W = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] HIT_COUNT,
    output logic [15:0] MISS_COUNT
`endif
);

    localparam int NBLK  = 2 ** INDEX_W;
    localparam int TAG_W = 6 - INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        UPDATE
    } state_t;

    state_t state_q, state_d;

    logic [3:0][7:0]  blk_q [NBLK];
    logic [TAG_W-1:0] tag_q [NBLK];
    logic [NBLK-1:0]  valid_q, valid_d;
    logic [NBLK-1:0]  dirty_q, dirty_d;

    logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
    logic [INDEX_W-1:0] miss_idx_q, miss_idx_d;
    logic [31:0]        fill_q, fill_d;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic [1:0]         req_off;
    logic               req;
    logic               hit;
    logic               busy;
    logic               wr_hit;
    logic               fill_en;

    assign req_tag = ADDRESS[7:INDEX_W+2];
    assign req_idx = ADDRESS[INDEX_W+1:2];
    assign req_off = ADDRESS[1:0];
    assign req     = READ | WRITE;
    assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign READDATA      = blk_q[req_idx][req_off];
    assign MEM_WRITEDATA = blk_q[miss_idx_q];
    // Reset must release the CPU immediately, even if a request is held.
    assign BUSYWAIT      = busy & ~RESET;

    always_comb begin
        state_d     = state_q;
        miss_tag_d  = miss_tag_q;
        miss_idx_d  = miss_idx_q;
        fill_d      = fill_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        wr_hit      = 1'b0;
        fill_en     = 1'b0;
        busy        = 1'b0;
        MEM_READ    = 1'b0;
        MEM_WRITE   = 1'b0;
        MEM_ADDRESS = '0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        if (WRITE) begin
                            wr_hit           = 1'b1;
                            dirty_d[req_idx] = 1'b1;
                        end
                    end else begin
                        busy       = 1'b1;
                        miss_tag_d = req_tag;
                        miss_idx_d = req_idx;
                        if (valid_q[req_idx] && dirty_q[req_idx]) begin
                            state_d = WRITEBACK;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
            end
            WRITEBACK: begin
                busy        = 1'b1;
                MEM_WRITE   = 1'b1;
                MEM_ADDRESS = {tag_q[miss_idx_q], miss_idx_q};
                if (!MEM_BUSYWAIT) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                busy        = 1'b1;
                MEM_READ    = 1'b1;
                MEM_ADDRESS = {miss_tag_q, miss_idx_q};
                if (!MEM_BUSYWAIT) begin
                    fill_d  = MEM_READDATA;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                busy                = 1'b1;
                fill_en             = 1'b1;
                valid_d[miss_idx_q] = 1'b1;
                dirty_d[miss_idx_q] = 1'b0;
                state_d             = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            fill_q     <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            miss_tag_q <= miss_tag_d;
            miss_idx_q <= miss_idx_d;
            fill_q     <= fill_d;
        end
    end

    // Data and tag storage carry no reset; valid bits gate their use.
    always_ff @(posedge CLK) begin
        if (wr_hit) begin
            blk_q[req_idx][req_off] <= WRITEDATA;
        end
        if (fill_en) begin
            blk_q[miss_idx_q] <= fill_q;
            tag_q[miss_idx_q] <= miss_tag_q;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;
    logic        after_fill_q, after_fill_d;

    // The access replayed right after a fill belongs to the miss, not a hit.
    always_comb begin
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        after_fill_d = (state_q == UPDATE);
        if (state_q == IDLE && req) begin
            if (hit && !after_fill_q && hit_cnt_q != 16'hFFFF) begin
                hit_cnt_d = hit_cnt_q + 16'd1;
            end
            if (!hit && miss_cnt_q != 16'hFFFF) begin
                miss_cnt_d = miss_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            after_fill_q <= 1'b0;
        end else begin
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            after_fill_q <= after_fill_d;
        end
    end

    assign HIT_COUNT  = hit_cnt_q;
    assign MISS_COUNT = miss_cnt_q;
`endif

endmodule
